// File: rtl/isp_frame_sequencer.sv
// rtl/isp_frame_sequencer.sv - ISP raster sequencer with double-buffered vignette config; ISP_FRAME_COUNT_EN adds frame_cnt
module isp_frame_sequencer #(
    parameter int H_ACTIVE = 32,
    parameter int V_ACTIVE = 32,
    parameter int H_BLANK  = 4,
    parameter int V_BLANK  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_shift,
    input  logic [5:0] cfg_cx,
    input  logic [5:0] cfg_cy,
    output logic [5:0] pix_x,
    output logic [5:0] pix_y,
    output logic       pix_valid,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_done,
    output logic       busy,
    output logic [2:0] gain_shift,
    output logic [5:0] gain_cx,
    output logic [5:0] gain_cy
`ifdef ISP_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

    localparam logic [5:0] X_LAST  = 6'(H_ACTIVE - 1);
    localparam logic [5:0] Y_LAST  = 6'(V_ACTIVE - 1);
    localparam logic [3:0] HB_LAST = 4'(H_BLANK - 1);
    localparam logic [3:0] VB_LAST = 4'(V_BLANK - 1);

    state_t     state_q, state_d;
    logic [5:0] x_q, x_d, y_q, y_d;
    logic [3:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       fdone_q, fdone_d;
    logic       busy_q, busy_d;
    logic       stop_q, stop_d;
    logic       stop_hit;

    logic       pend_q, pend_d;
    logic [2:0] pshift_q, pshift_d;
    logic [5:0] pcx_q, pcx_d, pcy_q, pcy_d;
    logic       release_q, release_d;
    logic       ready_q, ready_d;
    logic [2:0] gshift_q, gshift_d;
    logic [5:0] gcx_q, gcx_d, gcy_q, gcy_d;
    logic       xfer;

    // Raster walk: next state plus the registered pixel/sync outputs for the coming cycle
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        hsync_d  = 1'b0;
        vsync_d  = 1'b0;
        fdone_d  = 1'b0;
        stop_hit = stop_q | ((state_q != S_IDLE) & stop);
        stop_d   = stop_hit;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACTIVE;
                    x_d     = 6'd0;
                    y_d     = 6'd0;
                    valid_d = 1'b1;
                    hsync_d = 1'b1;
                    vsync_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (x_q == X_LAST) begin
                    state_d = S_HBLANK;
                    cnt_d   = 4'd0;
                end else begin
                    x_d     = x_q + 6'd1;
                    valid_d = 1'b1;
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    if (y_q < Y_LAST) begin
                        state_d = S_ACTIVE;
                        x_d     = 6'd0;
                        y_d     = y_q + 6'd1;
                        valid_d = 1'b1;
                        hsync_d = 1'b1;
                    end else begin
                        state_d = S_VBLANK;
                        cnt_d   = 4'd0;
                        fdone_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    stop_d = 1'b0;
                    if (stop_hit) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ACTIVE;
                        x_d     = 6'd0;
                        y_d     = 6'd0;
                        valid_d = 1'b1;
                        hsync_d = 1'b1;
                        vsync_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Config slot: gain only moves on the frame's first pixel; the slot is released one cycle later
    always_comb begin
        xfer      = cfg_valid & ready_q;
        pend_d    = pend_q;
        pshift_d  = pshift_q;
        pcx_d     = pcx_q;
        pcy_d     = pcy_q;
        gshift_d  = gshift_q;
        gcx_d     = gcx_q;
        gcy_d     = gcy_q;
        release_d = 1'b0;
        if (release_q) begin
            pend_d = 1'b0;
        end
        if (vsync_d && pend_q) begin
            gshift_d  = pshift_q;
            gcx_d     = pcx_q;
            gcy_d     = pcy_q;
            release_d = 1'b1;
        end
        if (xfer) begin
            pend_d   = 1'b1;
            pshift_d = cfg_shift;
            pcx_d    = cfg_cx;
            pcy_d    = cfg_cy;
        end
        ready_d = ~pend_d;
    end

    // State and output registers; reset drops any frame in flight without a frame_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= 6'd0;
            y_q       <= 6'd0;
            cnt_q     <= 4'd0;
            valid_q   <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            fdone_q   <= 1'b0;
            busy_q    <= 1'b0;
            stop_q    <= 1'b0;
            pend_q    <= 1'b0;
            pshift_q  <= 3'd0;
            pcx_q     <= 6'd0;
            pcy_q     <= 6'd0;
            release_q <= 1'b0;
            ready_q   <= 1'b1;
            gshift_q  <= 3'd3;
            gcx_q     <= 6'd16;
            gcy_q     <= 6'd16;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            fdone_q   <= fdone_d;
            busy_q    <= busy_d;
            stop_q    <= stop_d;
            pend_q    <= pend_d;
            pshift_q  <= pshift_d;
            pcx_q     <= pcx_d;
            pcy_q     <= pcy_d;
            release_q <= release_d;
            ready_q   <= ready_d;
            gshift_q  <= gshift_d;
            gcx_q     <= gcx_d;
            gcy_q     <= gcy_d;
        end
    end

`ifdef ISP_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame counter steps together with frame_done and wraps naturally at 16 bits
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (fdone_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Frame counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign pix_valid  = valid_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_done = fdone_q;
    assign busy       = busy_q;
    assign cfg_ready  = ready_q;
    assign gain_shift = gshift_q;
    assign gain_cx    = gcx_q;
    assign gain_cy    = gcy_q;

endmodule

// File: tb/tb_isp_frame_sequencer.sv
// tb/tb_isp_frame_sequencer.sv - self-checking bench for isp_frame_sequencer
module tb_isp_frame_sequencer;

    localparam int HA = 4, VA = 2, HB = 2, VB = 3;
    localparam int LINE = HA + HB;
    localparam int PERIOD = VA * LINE + VB;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
    logic [2:0] cfg_shift = 3'd0;
    logic [5:0] cfg_cx = 6'd0, cfg_cy = 6'd0;
    logic       cfg_ready, pix_valid, hsync, vsync, frame_done, busy;
    logic [5:0] pix_x, pix_y, gain_cx, gain_cy;
    logic [2:0] gain_shift;
`ifdef ISP_FRAME_COUNT_EN
    logic [15:0] frame_cnt;
`endif

    int errors = 0, checks = 0;

    isp_frame_sequencer #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_shift(cfg_shift), .cfg_cx(cfg_cx), .cfg_cy(cfg_cy),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .hsync(hsync), .vsync(vsync), .frame_done(frame_done), .busy(busy),
        .gain_shift(gain_shift), .gain_cx(gain_cx), .gain_cy(gain_cy)
`ifdef ISP_FRAME_COUNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        nxt(); nxt();
        rst_n = 1'b1;
    endtask

    function automatic logic [32:0] dut_vec();
        return {pix_valid, hsync, vsync, frame_done, busy, cfg_ready,
                pix_x, pix_y, gain_shift, gain_cx, gain_cy};
    endfunction

    // Reference model: position within the frame period, stop latch, one-entry config slot
    bit         m_run, m_stop, m_pend, m_applied;
    int         m_p;
    logic [5:0] m_x, m_y, m_pcx, m_pcy, m_gcx, m_gcy;
    logic [2:0] m_psh, m_gsh;

    function automatic logic [32:0] model_out();
        logic v, hs, vs, fd;
        logic [5:0] x, y;
        int col, row;
        v = 0; hs = 0; vs = 0; fd = 0; x = m_x; y = m_y;
        if (m_run) begin
            if (m_p < VA * LINE) begin
                col = m_p % LINE;
                row = m_p / LINE;
                v   = (col < HA);
                x   = v ? 6'(col) : 6'(HA - 1);
                y   = 6'(row);
                hs  = v && (col == 0);
                vs  = (m_p == 0);
            end else begin
                x  = 6'(HA - 1);
                y  = 6'(VA - 1);
                fd = (m_p == VA * LINE);
            end
        end
        return {v, hs, vs, fd, m_run, !m_pend, x, y, m_gsh, m_gcx, m_gcy};
    endfunction

    task automatic model_reset();
        m_run = 0; m_stop = 0; m_pend = 0; m_applied = 0; m_p = 0;
        m_x = 0; m_y = 0; m_psh = 0; m_pcx = 0; m_pcy = 0;
        m_gsh = 3'd3; m_gcx = 6'd16; m_gcy = 6'd16;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit cv,
                              input logic [2:0] sh, input logic [5:0] cx, input logic [5:0] cy);
        logic [32:0] o;
        bit fs, xfer;
        o = model_out();
        fs = 0;
        xfer = cv && !m_pend;
        if (m_run) begin
            m_x = o[26:21];
            m_y = o[20:15];
        end
        if (!m_run) begin
            if (st) begin m_run = 1; m_p = 0; fs = 1; end
        end else begin
            if (sp) m_stop = 1;
            if (m_p == PERIOD - 1) begin
                if (m_stop) begin m_run = 0; m_stop = 0; end
                else begin m_p = 0; fs = 1; end
            end else begin
                m_p++;
            end
        end
        if (m_applied) begin m_pend = 0; m_applied = 0; end
        if (fs && m_pend) begin
            m_gsh = m_psh; m_gcx = m_pcx; m_gcy = m_pcy; m_applied = 1;
        end
        if (xfer) begin
            m_pend = 1; m_psh = sh; m_pcx = cx; m_pcy = cy;
        end
    endtask

    typedef struct {
        logic       st, sp, cv;
        logic       v, hs, vs, fd, bz, rdy;
        logic [5:0] x, y;
        logic [2:0] sh;
    } vec_t;

    vec_t tab[18];
    int   xs[18] = '{0,0,1,2,3,3,3,0,1,2,3,3,3,3,3,3,0,1};
    int   ys[18] = '{0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,1,0,0};

    initial begin
        int acc, fd_seen;
        bit done2;

        for (int c = 0; c < 18; c++) begin
            tab[c].st  = (c == 0);
            tab[c].sp  = 1'b0;
            tab[c].cv  = (c == 3);
            tab[c].v   = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 16);
            tab[c].hs  = (c == 1) || (c == 7) || (c == 16);
            tab[c].vs  = (c == 1) || (c == 16);
            tab[c].fd  = (c == 13);
            tab[c].bz  = (c >= 1);
            tab[c].rdy = !(c >= 4 && c <= 16);
            tab[c].x   = 6'(xs[c]);
            tab[c].y   = 6'(ys[c]);
            tab[c].sh  = (c >= 16) ? 3'd5 : 3'd3;
        end

        // Directed timing table: start at 0, config (5,2,1) offered at 3
        do_reset();
        chk("reset_gain_cxcy", {gain_cx, gain_cy}, {6'd16, 6'd16});
        for (int c = 0; c < 18; c++) begin
            start = tab[c].st; stop = tab[c].sp; cfg_valid = tab[c].cv;
            cfg_shift = 3'd5; cfg_cx = 6'd2; cfg_cy = 6'd1;
            chk($sformatf("tableA_c%0d", c),
                {pix_valid, hsync, vsync, frame_done, busy, cfg_ready, pix_x, pix_y, gain_shift},
                {tab[c].v, tab[c].hs, tab[c].vs, tab[c].fd, tab[c].bz, tab[c].rdy,
                 tab[c].x, tab[c].y, tab[c].sh});
            if (c == 15) chk("A_gain_held_15", {gain_cx, gain_cy}, {6'd16, 6'd16});
            if (c == 16) chk("A_gain_new_16", {gain_cx, gain_cy}, {6'd2, 6'd1});
            nxt();
        end
        cfg_valid = 1'b0;

        // Second config held while slot busy
        do_reset();
        acc = -1; done2 = 0;
        for (int c = 0; c <= 32; c++) begin
            start = (c == 0);
            if (c == 3) begin
                cfg_valid = 1'b1; cfg_shift = 3'd5; cfg_cx = 6'd2; cfg_cy = 6'd1;
            end else if (c >= 4 && !done2) begin
                cfg_valid = 1'b1; cfg_shift = 3'd1; cfg_cx = 6'd7; cfg_cy = 6'd9;
            end else begin
                cfg_valid = 1'b0;
            end
            if (c == 16) chk("B_gain_first", {gain_shift, gain_cx, gain_cy}, {3'd5, 6'd2, 6'd1});
            if (c == 16) chk("B_ready_low_16", cfg_ready, 1'b0);
            if (c == 31) chk("B_gain_second", {vsync, gain_shift, gain_cx, gain_cy},
                             {1'b1, 3'd1, 6'd7, 6'd9});
            if (c >= 4 && cfg_valid && cfg_ready) begin acc = c; done2 = 1; end
            nxt();
        end
        cfg_valid = 1'b0;
        chk("B_accept_cycle", acc, 17);

        // Stop mid-frame, then start+stop together in idle
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            start = (c == 0) || (c == 8);
            stop  = (c == 5);
            if (c == 13) chk("C_frame_done_13", frame_done, 1'b1);
            if (c == 15) chk("C_busy_15", busy, 1'b1);
            if (c == 16) chk("C_idle_16", {busy, vsync, pix_valid}, 3'b000);
            if (c == 17) chk("C_hold_xy", {pix_x, pix_y}, {6'd3, 6'd1});
            nxt();
        end
        start = 1'b1; stop = 1'b1;
        nxt();
        start = 1'b0; stop = 1'b0;
        chk("C_start_wins", {busy, vsync}, 2'b11);
        for (int c = 1; c < 16; c++) nxt();
        chk("C_second_frame", {busy, vsync}, 2'b11);

        // Asynchronous reset mid-frame with a pending config
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            start = (c == 0);
            cfg_valid = (c == 3); cfg_shift = 3'd5; cfg_cx = 6'd2; cfg_cy = 6'd1;
            if (c < 8) nxt();
        end
        chk("D_pre_valid", pix_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("D_async_reset", dut_vec(), {6'b000001, 6'd0, 6'd0, 3'd3, 6'd16, 6'd16});
        nxt();
        rst_n = 1'b1;
        fd_seen = 0;
        for (int c = 0; c < 20; c++) begin
            nxt();
            if (frame_done || busy) fd_seen++;
        end
        chk("D_quiet_after_reset", fd_seen, 0);
        start = 1'b1;
        nxt();
        start = 1'b0;
        chk("D_restart", {vsync, pix_valid, gain_shift}, {1'b1, 1'b1, 3'd3});

`ifdef ISP_FRAME_COUNT_EN
        do_reset();
        for (int c = 0; c <= 45; c++) begin
            start = (c == 0);
            if (c == 0)  chk("E_cnt0", frame_cnt, 16'd0);
            if (c == 14) chk("E_cnt1", frame_cnt, 16'd1);
            if (c == 29) chk("E_cnt2", frame_cnt, 16'd2);
            if (c == 44) chk("E_cnt3", frame_cnt, 16'd3);
            nxt();
        end
        start = 1'b0;
`endif

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            chk($sformatf("rand_c%0d", c), dut_vec(), model_out());
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_shift = 3'($urandom_range(0, 7));
            cfg_cx    = 6'($urandom_range(0, 63));
            cfg_cy    = 6'($urandom_range(0, 63));
            model_step(start, stop, cfg_valid, cfg_shift, cfg_cx, cfg_cy);
            nxt();
        end
        start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
